lcd_reader: RTL

Read-side engine for the 4-bit HD44780-style character LCD on the VC707 board. It runs RW=1 bus cycles to fetch the busy flag/address counter (RS=0) or display RAM data (RS=1) as two nibbles, high nibble first. It can optionally poll the busy flag until it clears, with a bounded retry count. It sits beside the LCD write controller on the same internal 50 MHz clock. It owns the shared E/RS/RW pins and data bus only while `rd_active` is high.

---
 rtl/lcd_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - 4-bit HD44780 read engine (busy flag / address / data) with optional busy polling
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_rs selects BF/address (0) or data (1),
//                       req_poll repeats BF reads until BF=0 or MAX_POLLS reads
//   rsp_valid           one-cycle pulse with rsp_data (held) and rsp_timeout
//   rd_active           reader owns E/RS/RW and the data bus is not driven by the writer
//   lcd_data_i          DB7..DB4 from the panel
//   lcd_e/lcd_rs/lcd_rw reader-side LCD control pins
module lcd_reader #(
  parameter int CYCLES_PER_US = 50,
  parameter int MAX_POLLS     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       rd_active,
  input  logic [3:0] lcd_data_i,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  localparam int S_CYC = CYCLES_PER_US / 10;
  localparam int H_CYC = CYCLES_PER_US / 2;
  localparam int CW    = $clog2(H_CYC) + 1;
  localparam int PW    = $clog2(MAX_POLLS) + 1;

  localparam logic [CW-1:0] S_LAST   = CW'(S_CYC - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_CYC - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          nibble;
  logic          poll_q;
  logic [PW-1:0] poll_cnt;
  logic [7:0]    data_q;

  // Count including the byte that just completed; only used when polling
  // found BF=1, so the counter stops at MAX_POLLS and never wraps.
  logic [PW-1:0] poll_cnt_nxt;
  assign poll_cnt_nxt = poll_cnt + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      nibble      <= 1'b0;
      poll_q      <= 1'b0;
      poll_cnt    <= '0;
      data_q      <= 8'h00;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_timeout <= 1'b0;
      rd_active   <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            // Polling always reads the busy flag, whatever req_rs says.
            lcd_rs    <= req_poll ? 1'b0 : req_rs;
            lcd_rw    <= 1'b1;
            rd_active <= 1'b1;
            req_ready <= 1'b0;
            poll_q    <= req_poll;
            poll_cnt  <= '0;
            nibble    <= 1'b0;
            cnt       <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == S_LAST) begin
            cnt   <= '0;
            lcd_e <= 1'b1;
            state <= EHIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        EHIGH: begin
          if (cnt == H_LAST) begin
            // Sample at the very end of the E pulse, when read data has had
            // the whole pulse to settle.
            if (!nibble) data_q[7:4] <= lcd_data_i;
            else         data_q[3:0] <= lcd_data_i;
            cnt   <= '0;
            lcd_e <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        HOLD: begin
          if (cnt == S_LAST) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: begin
          if (cnt == H_LAST) begin
            cnt <= '0;
            if (!nibble) begin
              nibble <= 1'b1;
              state  <= SETUP;
            end else if (!poll_q || !data_q[7] || (poll_cnt_nxt == POLL_MAX)) begin
              // Byte finished: plain read, BF cleared, or poll budget spent.
              rsp_valid   <= 1'b1;
              rsp_data    <= data_q;
              rsp_timeout <= poll_q && data_q[7];
              rd_active   <= 1'b0;
              lcd_rs      <= 1'b0;
              lcd_rw      <= 1'b0;
              req_ready   <= 1'b1;
              state       <= IDLE;
            end else begin
              poll_cnt <= poll_cnt_nxt;
              nibble   <= 1'b0;
              state    <= SETUP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
